// File: rtl/lsu_ctrl.sv
// lsu_ctrl: MEM-stage load/store unit controller.
// Decodes each access to one of NUM_TGT targets (the last one is the default
// bus target), drives one-hot beat requests with byte strobes and lane-aligned
// write data, and returns sign/zero-extended load data. One request in flight.
// Optional feature macro: MISALIGN_SPLIT_EN -- when defined, misaligned
// halfword/word accesses are split into two aligned beats; when undefined they
// complete immediately with rsp_err=1 and no target beat.
module lsu_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_TGT    = 3,
    parameter logic [NUM_TGT*ADDR_WIDTH-1:0] TGT_BASE = {32'h0000_0000, 32'h0010_0000, 32'h0000_0000},
    parameter logic [NUM_TGT*ADDR_WIDTH-1:0] TGT_SIZE = {32'h0000_0000, 32'h0001_0000, 32'h0001_0000}
) (
    input  logic                          cpu_clk,
    input  logic                          cpu_rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_wr,
    input  logic [1:0]                    req_size,
    input  logic                          req_unsigned,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [DATA_WIDTH-1:0]         req_wdata,
    input  logic [5:0]                    req_rd,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [5:0]                    rsp_rd,
    output logic                          rsp_load,
    output logic                          rsp_err,
    output logic [NUM_TGT-1:0]            tgt_req,
    input  logic [NUM_TGT-1:0]            tgt_ready,
    output logic                          tgt_wr,
    output logic [ADDR_WIDTH-1:0]         tgt_addr,
    output logic [3:0]                    tgt_strb,
    output logic [DATA_WIDTH-1:0]         tgt_wdata,
    input  logic [NUM_TGT*DATA_WIDTH-1:0] tgt_rdata,
    input  logic [NUM_TGT-1:0]            tgt_rvalid
);

    localparam int TW = (NUM_TGT > 2) ? $clog2(NUM_TGT) : 1;
    localparam logic [TW-1:0] TGT_DEF = TW'(NUM_TGT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE0 = 3'd1,
        ST_WAIT0  = 3'd2,
        ST_ISSUE1 = 3'd3,
        ST_WAIT1  = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    // Lowest-index window containing addr; falls back to the default target.
    // The compare is widened by one bit so BASE+SIZE cannot wrap.
    function automatic logic [TW-1:0] decode_tgt(input logic [ADDR_WIDTH-1:0] addr);
        logic [TW-1:0]       idx;
        logic [ADDR_WIDTH:0] a;
        logic [ADDR_WIDTH:0] base;
        logic [ADDR_WIDTH:0] lim;
        idx = TGT_DEF;
        a   = {1'b0, addr};
        for (int i = NUM_TGT - 2; i >= 0; i--) begin
            base = {1'b0, TGT_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]};
            lim  = base + {1'b0, TGT_SIZE[i*ADDR_WIDTH +: ADDR_WIDTH]};
            if ((a >= base) && (a < lim)) begin
                idx = TW'(i);
            end
        end
        decode_tgt = idx;
    endfunction

    // Word-aligned beat address: target-relative, absolute for the default target.
    function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [TW-1:0] idx);
        logic [ADDR_WIDTH-1:0] r;
        if (idx == TGT_DEF) begin
            r = addr;
        end else begin
            r = addr - TGT_BASE[int'(idx)*ADDR_WIDTH +: ADDR_WIDTH];
        end
        r[1:0] = 2'b00;
        beat_addr = r;
    endfunction

    // Byte mask across two words: (1<<bytes)-1 shifted to the byte offset.
    function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] m;
        case (size)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            default: m = 8'h0F;
        endcase
        byte_mask = m << off;
    endfunction

    // Align the two-word read pair down by the byte offset and extend.
    function automatic logic [31:0] extend_load(input logic [63:0] pair, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
        logic [63:0] sh;
        logic [31:0] r;
        sh = pair >> {off, 3'b000};
        case (size)
            2'd0:    r = uns ? {24'h00_0000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'd1:    r = uns ? {16'h0000, sh[15:0]}    : {{16{sh[15]}}, sh[15:0]};
            default: r = sh[31:0];
        endcase
        extend_load = r;
    endfunction

    function automatic logic [NUM_TGT-1:0] one_hot(input logic [TW-1:0] idx);
        logic [NUM_TGT-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        one_hot = r;
    endfunction

    state_t                  state_r, next_state_s;
    logic                    wr_r, uns_r, split_r;
    logic [1:0]              size_r, off_r;
    logic [5:0]              rd_r;
    logic [TW-1:0]           t0_r, t1_r;
    logic [ADDR_WIDTH-1:0]   addr1_r;
    logic [3:0]              strb1_r;
    logic [DATA_WIDTH-1:0]   wd1_r, lo_r, hi_r;

    logic [NUM_TGT-1:0]      tgt_req_r;
    logic                    tgt_wr_r;
    logic [ADDR_WIDTH-1:0]   tgt_addr_r;
    logic [3:0]              tgt_strb_r;
    logic [DATA_WIDTH-1:0]   tgt_wdata_r;
    logic                    rsp_valid_r, rsp_load_r, rsp_err_r;
    logic [DATA_WIDTH-1:0]   rsp_data_r;
    logic [5:0]              rsp_rd_r;

    logic [1:0]              req_off_s;
    logic [7:0]              req_mask_s;
    logic                    req_split_s;
    logic                    misalign_err_s;
    logic [63:0]             req_wide_s;
    logic [ADDR_WIDTH-1:0]   req_a1_s;
    logic [TW-1:0]           req_t0_s, req_t1_s;
    logic [TW-1:0]           cur_t_s;
    logic                    cur_ready_s, cur_rvalid_s;
    logic [DATA_WIDTH-1:0]   cur_rdata_s;
    logic [63:0]             pair_s;
    logic [DATA_WIDTH-1:0]   load_data_s;

    // Decode of the incoming request: target, strobes, split, shifted write data.
    always_comb begin
        req_off_s   = req_addr[1:0];
        req_mask_s  = byte_mask(req_size, req_off_s);
        req_split_s = |req_mask_s[7:4];
        req_wide_s  = {32'h0000_0000, req_wdata} << {req_off_s, 3'b000};
        req_a1_s    = {req_addr[ADDR_WIDTH-1:2], 2'b00} + ADDR_WIDTH'(4);
        req_t0_s    = decode_tgt(req_addr);
        req_t1_s    = decode_tgt(req_a1_s);
`ifdef MISALIGN_SPLIT_EN
        misalign_err_s = 1'b0;
`else
        misalign_err_s = req_split_s;
`endif
    end

    // Select the handshake/data of the target owning the current beat and
    // assemble the read pair; data arriving this cycle is merged in WAITx.
    always_comb begin
        if ((state_r == ST_ISSUE1) || (state_r == ST_WAIT1)) begin
            cur_t_s = t1_r;
        end else begin
            cur_t_s = t0_r;
        end
        cur_ready_s  = tgt_ready[cur_t_s];
        cur_rvalid_s = tgt_rvalid[cur_t_s];
        cur_rdata_s  = tgt_rdata[int'(cur_t_s)*DATA_WIDTH +: DATA_WIDTH];
        case (state_r)
            ST_WAIT0: pair_s = {32'h0000_0000, cur_rdata_s};
            ST_WAIT1: pair_s = {cur_rdata_s, lo_r};
            default:  pair_s = {hi_r, lo_r};
        endcase
        load_data_s = extend_load(pair_s, off_r, size_r, uns_r);
    end

    // Next-state logic of the access sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    next_state_s = misalign_err_s ? ST_RESP : ST_ISSUE0;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE0: begin
                if (cur_ready_s) begin
                    if (!wr_r) begin
                        next_state_s = ST_WAIT0;
                    end else begin
                        next_state_s = split_r ? ST_ISSUE1 : ST_RESP;
                    end
                end else begin
                    next_state_s = ST_ISSUE0;
                end
            end
            ST_WAIT0: begin
                if (cur_rvalid_s) begin
                    next_state_s = split_r ? ST_ISSUE1 : ST_RESP;
                end else begin
                    next_state_s = ST_WAIT0;
                end
            end
            ST_ISSUE1: begin
                if (cur_ready_s) begin
                    next_state_s = wr_r ? ST_RESP : ST_WAIT1;
                end else begin
                    next_state_s = ST_ISSUE1;
                end
            end
            ST_WAIT1: begin
                if (cur_rvalid_s) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request latch, beat outputs, read capture and response registers.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            wr_r        <= 1'b0;
            uns_r       <= 1'b0;
            split_r     <= 1'b0;
            size_r      <= 2'd0;
            off_r       <= 2'd0;
            rd_r        <= 6'd0;
            t0_r        <= '0;
            t1_r        <= '0;
            addr1_r     <= '0;
            strb1_r     <= 4'h0;
            wd1_r       <= '0;
            lo_r        <= '0;
            hi_r        <= '0;
            tgt_req_r   <= '0;
            tgt_wr_r    <= 1'b0;
            tgt_addr_r  <= '0;
            tgt_strb_r  <= 4'h0;
            tgt_wdata_r <= '0;
            rsp_valid_r <= 1'b0;
            rsp_load_r  <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_data_r  <= '0;
            rsp_rd_r    <= 6'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        wr_r    <= req_wr;
                        uns_r   <= req_unsigned;
                        split_r <= req_split_s;
                        size_r  <= req_size;
                        off_r   <= req_off_s;
                        rd_r    <= req_rd;
                        t0_r    <= req_t0_s;
                        t1_r    <= req_t1_s;
                        addr1_r <= beat_addr(req_a1_s, req_t1_s);
                        strb1_r <= req_mask_s[7:4];
                        wd1_r   <= req_wr ? req_wide_s[63:32] : 32'h0000_0000;
                        lo_r    <= '0;
                        hi_r    <= '0;
                        if (misalign_err_s) begin
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                            rsp_load_r  <= ~req_wr;
                            rsp_data_r  <= '0;
                            rsp_rd_r    <= req_rd;
                        end else begin
                            tgt_req_r   <= one_hot(req_t0_s);
                            tgt_wr_r    <= req_wr;
                            tgt_addr_r  <= beat_addr(req_addr, req_t0_s);
                            tgt_strb_r  <= req_mask_s[3:0];
                            tgt_wdata_r <= req_wr ? req_wide_s[31:0] : 32'h0000_0000;
                        end
                    end
                end
                ST_ISSUE0: begin
                    if (cur_ready_s) begin
                        if (wr_r && split_r) begin
                            tgt_req_r   <= one_hot(t1_r);
                            tgt_addr_r  <= addr1_r;
                            tgt_strb_r  <= strb1_r;
                            tgt_wdata_r <= wd1_r;
                        end else begin
                            tgt_req_r   <= '0;
                            tgt_wr_r    <= 1'b0;
                            tgt_addr_r  <= '0;
                            tgt_strb_r  <= 4'h0;
                            tgt_wdata_r <= '0;
                        end
                        if (wr_r && !split_r) begin
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b0;
                            rsp_load_r  <= 1'b0;
                            rsp_data_r  <= '0;
                            rsp_rd_r    <= rd_r;
                        end
                    end
                end
                ST_WAIT0: begin
                    if (cur_rvalid_s) begin
                        lo_r <= cur_rdata_s;
                        if (split_r) begin
                            tgt_req_r   <= one_hot(t1_r);
                            tgt_wr_r    <= 1'b0;
                            tgt_addr_r  <= addr1_r;
                            tgt_strb_r  <= strb1_r;
                            tgt_wdata_r <= '0;
                        end else begin
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b0;
                            rsp_load_r  <= 1'b1;
                            rsp_data_r  <= load_data_s;
                            rsp_rd_r    <= rd_r;
                        end
                    end
                end
                ST_ISSUE1: begin
                    if (cur_ready_s) begin
                        tgt_req_r   <= '0;
                        tgt_wr_r    <= 1'b0;
                        tgt_addr_r  <= '0;
                        tgt_strb_r  <= 4'h0;
                        tgt_wdata_r <= '0;
                        if (wr_r) begin
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b0;
                            rsp_load_r  <= 1'b0;
                            rsp_data_r  <= '0;
                            rsp_rd_r    <= rd_r;
                        end
                    end
                end
                ST_WAIT1: begin
                    if (cur_rvalid_s) begin
                        hi_r        <= cur_rdata_s;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b0;
                        rsp_load_r  <= 1'b1;
                        rsp_data_r  <= load_data_s;
                        rsp_rd_r    <= rd_r;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        rsp_err_r   <= 1'b0;
                        rsp_load_r  <= 1'b0;
                        rsp_data_r  <= '0;
                        rsp_rd_r    <= 6'd0;
                    end
                end
                default: begin
                    tgt_req_r   <= '0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Accept only in IDLE and never while reset is applied.
    assign req_ready = (state_r == ST_IDLE) && !cpu_rst;
    assign tgt_req   = tgt_req_r;
    assign tgt_wr    = tgt_wr_r;
    assign tgt_addr  = tgt_addr_r;
    assign tgt_strb  = tgt_strb_r;
    assign tgt_wdata = tgt_wdata_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_rd    = rsp_rd_r;
    assign rsp_load  = rsp_load_r;
    assign rsp_err   = rsp_err_r;

endmodule
